motor_pwm_driver: RTL and testbench

Converts the signed assist command from the assistance algorithm into the physical motor gate PWM signal. It clamps the command and applies it only at PWM period boundaries so no pulse is ever truncated. Increases in duty are slew-limited; decreases take effect at once. Brake is a hard override, followed by a restart hold-off. Sits directly downstream of the assistance algorithm and drives the motor controller input pin.

---
 rtl/motor_pwm_driver_pkg.sv | 21 ++
 rtl/motor_pwm_driver_if.sv | 30 +++
 rtl/motor_pwm_driver_timebase.sv | 39 +++
 rtl/motor_pwm_driver.sv | 106 ++++++++++
 tb/tb_motor_pwm_driver.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and constants for the motor PWM driver: FSM encoding,
// duty/period limits and the command-to-target conversion.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BRAKE   = 2'd2,
    HOLDOFF = 2'd3
  } pwm_state_t;

  localparam int DUTY_MAX     = 511;
  localparam int PERIOD_TICKS = 511;

  // Negative commands mean "no assist"; a 10-bit signed value can never
  // exceed 511, so the low nine bits are already a valid duty.
  function automatic logic [8:0] cmd_to_target(input logic signed [9:0] cmd);
    return cmd[9] ? 9'd0 : cmd[8:0];
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command/status bundle between the assistance algorithm (master) and the
// motor PWM driver (slave).
interface motor_pwm_driver_if;

  logic signed [9:0] pwm_cmd;
  logic              brake;
  logic              pwm_out;
  logic        [8:0] duty_applied;
  logic              period_start;
  logic        [1:0] state_dbg;

  modport master (
    output pwm_cmd,
    output brake,
    input  pwm_out,
    input  duty_applied,
    input  period_start,
    input  state_dbg
  );

  modport slave (
    input  pwm_cmd,
    input  brake,
    output pwm_out,
    output duty_applied,
    output period_start,
    output state_dbg
  );

endinterface

// File: rtl/motor_pwm_driver_timebase.sv
// PWM timebase: a prescaler dividing clk into counter ticks and a 9-bit
// period counter running 0..510, with a one-clk pulse on each wrap.
module pwm_timebase
  import motor_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] count,
  output logic       period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(PRESCALE - 1));

  // Prescaler: free-running 0..PRESCALE-1, ticking on its wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  // Period counter and the registered pulse marking the clk where it returns to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= tick && (count == 9'(PERIOD_TICKS - 1));
      if (tick) count <= (count == 9'(PERIOD_TICKS - 1)) ? 9'd0 : count + 9'd1;
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: turns the signed assist command into the gate PWM,
// applying new duty only at period boundaries, slew-limiting increases,
// and forcing the output off during brake and the following hold-off.
module motor_pwm_driver #(
  parameter int PRESCALE        = 4,
  parameter int RAMP_STEP       = 8,
  parameter int HOLDOFF_PERIODS = 16
) (
  input  logic                clk,
  input  logic                rst,
  motor_pwm_driver_if.slave   bus
);

  import motor_pkg::*;

  pwm_state_t state;
  logic [8:0] duty;
  logic [8:0] count;
  logic [8:0] tgt;
  logic [8:0] ramp;
  logic [9:0] ramp_sum;
  logic [7:0] hold;
  logic       period_start;
  logic       pwm;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .period_start (period_start)
  );

  assign tgt      = cmd_to_target(bus.pwm_cmd);
  assign ramp_sum = {1'b0, duty} + 10'(RAMP_STEP);

  // Duty for the next period: drops straight to the target, rises by at
  // most RAMP_STEP; the 10-bit sum cannot wrap past the 511 ceiling.
  always_comb begin
    if (tgt <= duty)                   ramp = tgt;
    else if ({1'b0, tgt} <= ramp_sum)  ramp = tgt;
    else                               ramp = ramp_sum[8:0];
  end

  // Control FSM; pwm is compared against the duty being loaded this edge so
  // a new duty covers a whole period and the pulse is never truncated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      duty  <= '0;
      pwm   <= 1'b0;
      hold  <= '0;
    end else if (bus.brake) begin
      state <= BRAKE;
      duty  <= '0;
      pwm   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (period_start && (tgt != 9'd0)) begin
            state <= RUN;
            duty  <= ramp;
            pwm   <= (count < ramp);
          end else begin
            duty  <= '0;
            pwm   <= 1'b0;
          end
        end
        RUN: begin
          if (period_start) begin
            duty <= ramp;
            pwm  <= (count < ramp);
            if (ramp == 9'd0) state <= IDLE;
          end else begin
            pwm  <= (count < duty);
          end
        end
        BRAKE: begin
          duty <= '0;
          pwm  <= 1'b0;
          if (HOLDOFF_PERIODS == 0) begin
            state <= IDLE;
          end else begin
            hold  <= 8'(HOLDOFF_PERIODS);
            state <= HOLDOFF;
          end
        end
        default: begin
          duty <= '0;
          pwm  <= 1'b0;
          if (period_start) begin
            hold <= hold - 8'd1;
            if (hold <= 8'd1) state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.pwm_out      = pwm;
  assign bus.duty_applied = duty;
  assign bus.period_start = period_start;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Testbench for motor_pwm_driver (PRESCALE=1, RAMP_STEP=16, HOLDOFF_PERIODS=2):
// a table of command steps, hand sequences for brake/hold-off and async
// reset, and random commands/brakes, all scored against a period-level model.
module tb_motor_pwm_driver;

  localparam int PERIOD = 511;
  localparam int STEP   = 16;
  localparam int HOLD   = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_BRAKE = 2, S_HOLDOFF = 3;

  typedef struct {
    int cmd;
    int periods;
    int exp_duty;
    int exp_state;
  } vec_t;

  logic clk;
  logic rst;

  motor_pwm_driver_if bus();

  motor_pwm_driver #(
    .PRESCALE        (1),
    .RAMP_STEP       (STEP),
    .HOLDOFF_PERIODS (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state, in terms of periods and edges since reset release
  int m_edges;
  int m_duty;
  int m_mode;
  int m_hold;
  int win_duty;
  int win_high;
  bit win_started;
  bit win_clean;

  vec_t vecs[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cmd, input bit brk);
    bus.pwm_cmd = 10'(cmd);
    bus.brake   = brk;
  endtask

  function automatic int cmd_target(input int cmd);
    return (cmd < 0) ? 0 : cmd;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_edges     = 0;
    m_duty      = 0;
    m_mode      = S_IDLE;
    m_hold      = 0;
    win_started = 0;
    win_clean   = 0;
    win_high    = 0;
    win_duty    = 0;
  endtask

  // One clk: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    int tgt;
    bit ps;
    @(posedge clk);
    tgt = cmd_target(int'(bus.pwm_cmd));
    ps  = (m_edges > 0) && (m_edges % PERIOD == 0);
    if (bus.brake) win_clean = 0;
    m_edges++;
    if (bus.brake) begin
      m_mode = S_BRAKE;
      m_duty = 0;
    end else if (m_mode == S_BRAKE) begin
      m_hold = HOLD;
      m_mode = (HOLD > 0) ? S_HOLDOFF : S_IDLE;
    end else if (ps) begin
      if (m_mode == S_IDLE && tgt > 0) begin
        m_mode = S_RUN;
        m_duty = min2(tgt, STEP);
      end else if (m_mode == S_RUN) begin
        m_duty = (tgt <= m_duty) ? tgt : min2(tgt, m_duty + STEP);
        if (m_duty == 0) m_mode = S_IDLE;
      end else if (m_mode == S_HOLDOFF) begin
        m_hold--;
        if (m_hold == 0) m_mode = S_IDLE;
      end
    end
    @(negedge clk);
    checkOutput("duty_applied", int'(bus.duty_applied), m_duty);
    checkOutput("state_dbg", int'(bus.state_dbg), m_mode);
    checkOutput("period_start", int'(bus.period_start), (m_edges % PERIOD == 0) ? 1 : 0);
    if (m_duty == 0)   checkOutput("pwm_off", int'(bus.pwm_out), 0);
    if (m_duty == 511) checkOutput("pwm_full", int'(bus.pwm_out), 1);
    if ((m_edges - 1) % PERIOD == 0) begin
      if (win_started && win_clean) checkOutput("pwm_high_per_period", win_high, win_duty);
      win_started = 1;
      win_clean   = 1;
      win_high    = 0;
      win_duty    = m_duty;
    end
    if (bus.pwm_out) win_high++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until a period_start pulse is observed, bounded to just over one period.
  task automatic wait_ps();
    bit seen;
    seen = 0;
    for (int i = 0; i < PERIOD + 5 && !seen; i++) begin
      step();
      if (bus.period_start) seen = 1;
    end
    if (!seen) checkOutput("period_start_timeout", 0, 1);
  endtask

  initial begin
    vecs[0]  = '{0,    1,  0,   S_IDLE};
    vecs[1]  = '{100,  1,  16,  S_RUN};
    vecs[2]  = '{100,  5,  96,  S_RUN};
    vecs[3]  = '{100,  1,  100, S_RUN};
    vecs[4]  = '{20,   1,  20,  S_RUN};
    vecs[5]  = '{-50,  1,  0,   S_IDLE};
    vecs[6]  = '{511,  1,  16,  S_RUN};
    vecs[7]  = '{511,  30, 496, S_RUN};
    vecs[8]  = '{511,  1,  511, S_RUN};
    vecs[9]  = '{-512, 1,  0,   S_IDLE};
    vecs[10] = '{40,   2,  32,  S_RUN};
    vecs[11] = '{40,   1,  40,  S_RUN};
    vecs[12] = '{0,    1,  0,   S_IDLE};

    // Reset state
    rst = 1'b1;
    applyStimulus(0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_out", int'(bus.pwm_out), 0);
    checkOutput("reset_duty", int'(bus.duty_applied), 0);
    checkOutput("reset_state", int'(bus.state_dbg), S_IDLE);
    checkOutput("reset_period_start", int'(bus.period_start), 0);
    rst = 1'b0;

    // Offset the phase so table commands change mid-period
    run_steps(200);

    // Table: each command is held for a number of period boundaries
    begin
      int prev_duty;
      prev_duty = 0;
      for (int v = 0; v < 13; v++) begin
        applyStimulus(vecs[v].cmd, 1'b0);
        step();
        checkOutput("mid_period_duty_hold", int'(bus.duty_applied), prev_duty);
        run_steps(vecs[v].periods * PERIOD - 1);
        checkOutput("table_duty", int'(bus.duty_applied), vecs[v].exp_duty);
        checkOutput("table_state", int'(bus.state_dbg), vecs[v].exp_state);
        prev_duty = vecs[v].exp_duty;
      end
    end

    // Brake at duty 300 mid-period, then the hold-off and restart ramp
    applyStimulus(300, 1'b0);
    run_steps(19 * PERIOD);
    checkOutput("pre_brake_duty", int'(bus.duty_applied), 300);
    applyStimulus(300, 1'b1);
    step();
    checkOutput("brake_pwm", int'(bus.pwm_out), 0);
    checkOutput("brake_duty", int'(bus.duty_applied), 0);
    checkOutput("brake_state", int'(bus.state_dbg), S_BRAKE);
    run_steps(5);
    applyStimulus(300, 1'b0);
    step();
    checkOutput("holdoff_entry", int'(bus.state_dbg), S_HOLDOFF);
    wait_ps();
    step();
    checkOutput("holdoff_after_one", int'(bus.state_dbg), S_HOLDOFF);
    wait_ps();
    step();
    checkOutput("holdoff_exit_idle", int'(bus.state_dbg), S_IDLE);
    checkOutput("holdoff_exit_duty", int'(bus.duty_applied), 0);
    wait_ps();
    step();
    checkOutput("restart_state", int'(bus.state_dbg), S_RUN);
    checkOutput("restart_duty", int'(bus.duty_applied), 16);

    // Asynchronous reset in the high part of a duty-200 period
    applyStimulus(200, 1'b0);
    run_steps(12 * PERIOD);
    checkOutput("pre_reset_duty", int'(bus.duty_applied), 200);
    wait_ps();
    run_steps(50);
    checkOutput("pre_reset_pwm", int'(bus.pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_pwm", int'(bus.pwm_out), 0);
    checkOutput("async_reset_duty", int'(bus.duty_applied), 0);
    checkOutput("async_reset_state", int'(bus.state_dbg), S_IDLE);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_steps(2 * PERIOD);
    checkOutput("post_reset_duty", int'(bus.duty_applied), 16);
    checkOutput("post_reset_state", int'(bus.state_dbg), S_RUN);

    // Random commands and brake pulses against the model
    for (int r = 0; r < 10; r++) begin
      int c;
      c = int'($urandom_range(0, 1023));
      if (c > 511) c = c - 1024;
      applyStimulus(c, 1'b0);
      run_steps(int'($urandom_range(100, 1200)));
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(c, 1'b1);
        run_steps(int'($urandom_range(1, 30)));
        applyStimulus(c, 1'b0);
      end
    end
    run_steps(PERIOD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
